// File: rtl/vend_ctrl.sv
// vend_ctrl: coin-credit vending controller with serial change return,
// cancel/refund, stock tracking with sold-out lockout, refill and overflow reject.
module vend_ctrl #(
    parameter  int unsigned PRICE = 5,
    parameter  int unsigned CW    = 2,
    parameter  int unsigned MW    = 8,
    parameter  int unsigned STOCK = 8,
    localparam int unsigned SW    = $clog2(STOCK + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ena,
    input  logic [CW-1:0] half_dollar,
    input  logic [CW-1:0] one_dollar,
    input  logic          cancel,
    input  logic          refill,
    output logic          half_out,
    output logic          dispense,
    output logic          collect,
    output logic          reject,
    output logic [1:0]    state,
    output logic [MW-1:0] money,
    output logic [SW-1:0] stock,
    output logic          sold_out
);

    localparam int unsigned SUMW = MW + 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DISP   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [MW-1:0]   money_q, money_d;
    logic [SW-1:0]   stock_q, stock_d;
    logic            collect_q, collect_d;

    logic [SUMW-1:0] sum;
    logic            coins_nz;
    logic            overflow;
    logic            can_take;
    logic            accept;

    // Coin arithmetic and acceptance decision for the current cycle
    always_comb begin
        sum      = SUMW'(money_q) + SUMW'(half_dollar) + (SUMW'(one_dollar) << 1);
        coins_nz = (|half_dollar) | (|one_dollar);
        overflow = |sum[SUMW-1:MW];
        can_take = (state_q == IDLE) || (state_q == ACCUM);
        accept   = ena & can_take & ~sold_out & ~cancel & ~overflow;
    end

    // Next-state, credit, stock and collect computation
    always_comb begin
        state_d   = state_q;
        money_d   = money_q;
        stock_d   = stock_q;
        collect_d = 1'b0;
        case (state_q)
            IDLE, ACCUM: begin
                if (ena) begin
                    if (cancel) begin
                        // credit is kept and paid out by CHANGE; IDLE has none
                        if (state_q == ACCUM) begin
                            state_d = CHANGE;
                        end
                    end else if (accept && coins_nz) begin
                        money_d = sum[MW-1:0];
                        state_d = (sum >= SUMW'(PRICE)) ? DISP : ACCUM;
                    end
                end
            end
            DISP: begin
                money_d = money_q - MW'(PRICE);
                stock_d = stock_q - SW'(1);
                if (money_q == MW'(PRICE)) begin
                    state_d   = IDLE;
                    collect_d = 1'b1;
                end else begin
                    state_d = CHANGE;
                end
            end
            CHANGE: begin
                money_d = money_q - MW'(1);
                if (money_q <= MW'(1)) begin
                    state_d   = IDLE;
                    collect_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // refill overrides the dispense decrement
        if (refill) begin
            stock_d = SW'(STOCK);
        end
    end

    // State and datapath registers; reset discards any credit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            money_q   <= '0;
            stock_q   <= SW'(STOCK);
            collect_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            money_q   <= money_d;
            stock_q   <= stock_d;
            collect_q <= collect_d;
        end
    end

    // Output decodes
    always_comb begin
        state    = state_q;
        money    = money_q;
        stock    = stock_q;
        collect  = collect_q;
        sold_out = (stock_q == '0);
        dispense = (state_q == DISP);
        half_out = (state_q == CHANGE);
        reject   = reset & ena & coins_nz & ~accept;
    end

endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
- Parametrised successor to the single-product drink controller.
- Accumulates coin credit in half-unit steps and releases one item when credit reaches PRICE.
- Returns change serially as one half-unit coin pulse per cycle.
- Adds a cancel/refund path, stock tracking with sold-out lockout and refill, and an overflow reject.
- Sits between the coin-acceptor front end and the dispense/coin-return mechanics.

Parameters:
- PRICE, 5, item price in half-unit coins (5 = 2.5); 1 <= PRICE <= 2^MW-1.
- CW, 2, width of per-cycle coin-count inputs.
- MW, 8, credit register width (half units).
- STOCK, 8, item capacity loaded at reset and on refill; SW = $clog2(STOCK+1).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; low clears the block immediately.
- ena  in  1  accepts coins and cancel when high.
- half_dollar  in  CW  number of 0.5 coins inserted this cycle.
- one_dollar  in  CW  number of 1.0 coins inserted this cycle (worth 2 half units each).
- cancel  in  1  refund request.
- refill  in  1  reload stock to STOCK.
- half_out  out  1  one half-unit coin returned this cycle.
- dispense  out  1  item released this cycle.
- collect  out  1  one-cycle pulse: transaction finished.
- reject  out  1  coins presented this cycle are not accepted (combinational).
- state  out  2  FSM state.
- money  out  MW  current credit in half units.
- stock  out  SW  remaining items.
- sold_out  out  1  stock == 0.

Behaviour:
- States: IDLE=0, ACCUM=1, DISP=2, CHANGE=3.
- Reset values: state IDLE, money 0, stock STOCK, collect 0. half_out, dispense and reject read 0 during reset.
- Moore decodes: dispense = (state==DISP); half_out = (state==CHANGE).
- Coin sum: sum = money + half_dollar + 2*one_dollar, computed at MW+2 bits. overflow = sum > 2^MW-1.
- Acceptance: accept = ena & state in {IDLE,ACCUM} & !sold_out & !cancel & !overflow.
- reject = ena & (half_dollar|one_dollar) != 0 & !accept. A rejected cycle leaves money unchanged.
- IDLE/ACCUM, ena=0: hold all state; coins and cancel ignored; reject=0.
- IDLE/ACCUM, accept with nonzero coins: money <= sum[MW-1:0].
  - Next state DISP if sum >= PRICE.
  - Otherwise ACCUM (IDLE is not re-entered with sum 0).
- ACCUM, ena & cancel: go to CHANGE; money kept for refund. cancel wins over same-cycle coins, which are rejected.
- IDLE, cancel: no effect.
- DISP (exactly 1 cycle):
  - money <= money-PRICE.
  - stock <= stock-1, unless refill is high that cycle, in which case stock <= STOCK.
  - If money == PRICE: next state IDLE, collect=1 on the next cycle.
  - Else: next state CHANGE.
- CHANGE: money <= money-1 each cycle.
  - When money == 1: next state IDLE, collect=1 on the next cycle.
  - Total half_out pulses equal the credit at CHANGE entry.
- DISP and CHANGE run to completion regardless of ena and cancel. Coins presented in these states are rejected.
- refill: stock <= STOCK in any state, takes priority over the DISP decrement.
- sold_out: coins are rejected. Credit already in ACCUM stays refundable by cancel.
- Latency:
  - Coins reaching PRICE give dispense in the next cycle.
  - Change starts the cycle after DISP.
  - collect is registered: high in the cycle after the last dispense/half_out cycle, coincident with state IDLE.
- Async reset mid-transaction: credit is discarded; no refund and no collect.

Test Plan:
- Defaults, ena=1, half_dollar=1 and one_dollar=2 for one cycle -> money=5, DISP next cycle (dispense=1), then IDLE, money=0, collect=1, zero half_out pulses, stock=7.
- half_dollar=2, one_dollar=2 -> money=6; dispense 1 cycle; half_out for 1 cycle; collect; money=0; stock decremented by 1.
- one_dollar=1 -> ACCUM, money=2; cancel with half_dollar=1 in the same cycle -> reject=1, CHANGE, exactly 2 half_out pulses, collect, no dispense, stock unchanged.
- Eight vends at price 5 -> stock=0, sold_out=1; next one_dollar=1 -> reject=1, money stays 0; refill -> stock=8, next coin accepted.
- MW=4, PRICE=15: build money=14, then one_dollar=1 (sum 16) -> reject=1, money stays 14; half_dollar=1 -> money=15, dispense.
- Reset low during CHANGE with money=3 -> immediately state=0, money=0, half_out=0, stock=STOCK; after release, no collect pulse.
